bnn_param_loader: RTL and testbench
===================================

Name: bnn_param_loader

Overview:
- Upstream parameter-loading stage for the 8-8-4 BNN core (20 neurons, 8-bit weight plus 4-bit threshold each).
- Deserialises a 4-bit nibble stream from the bidirectional pins into complete per-neuron records.
- Issues one registered write strobe per neuron into the neuron parameter store.
- Tracks progress, detects truncated records and produces a running checksum, so host software can confirm the load.

Parameters:
NUM_NEURONS, 20, number of neuron records in one full load (layer1 0-7, layer2 8-15, layer3 16-19)
ADDR_W, 5, width of neuron index; must satisfy 2**ADDR_W >= NUM_NEURONS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ena  input  1  design enable; when low, no nibble is accepted and all state holds
start  input  1  single-cycle restart: clears index, record phase, done, err, checksum
load_en  input  1  nibble-valid qualifier (uio_in[3] at top level)
nibble  input  4  data nibble (uio_in[7:4] at top level)
wr_en  output  1  one-cycle write strobe to parameter store
wr_addr  output  ADDR_W  neuron index being written
wr_weight  output  8  {hi nibble, lo nibble}
wr_thresh  output  4  threshold nibble
busy  output  1  high while a record is partially received (phase HI or TH)
done  output  1  sticky; all NUM_NEURONS records written
err  output  1  sticky; a record was truncated
checksum  output  8  mod-256 sum of every accepted nibble since last start/reset

Behaviour:
- Reset (sync, highest priority): phase=LO, index=0, wr_en=0, wr_addr=0, wr_weight=0, wr_thresh=0, done=0, err=0, checksum=0.
- Accept condition: ena && load_en && !done && !start. Only one nibble is accepted per clock.
- Record format: 3 nibbles in order: weight[3:0], weight[7:4], threshold[3:0].
- Phase FSM:
  - LO: on accept, latch lo and go to HI.
  - HI: on accept, latch hi and go to TH.
  - TH: on accept, go to LO and schedule a write.
- Write timing: on the edge that accepts the TH nibble, register wr_en=1, wr_addr=index, wr_weight={hi,lo}, wr_thresh=nibble. The outputs are therefore visible in the cycle after the TH accept, for exactly 1 cycle.
- Index increments on the same edge. If index==NUM_NEURONS-1, set done=1 and leave index=NUM_NEURONS-1; do not wrap.
- wr_en deasserts in the next cycle unless another write is scheduled. Back-to-back writes are impossible; the minimum spacing is 3 cycles.
- wr_addr, wr_weight and wr_thresh hold their last written values while wr_en=0.
- done state:
  - Further nibbles are ignored: no checksum update and no wr_en.
  - done stays high until start or reset.
- Truncation:
  - Trigger: in phase HI or TH with ena=1 and load_en=0.
  - Response: set err=1, return to LO, discard the partial record, keep index unchanged so the same neuron is reloaded.
  - The checksum keeps the nibbles already accepted.
  - With ena=0 there is no truncation check and everything holds.
- start:
  - Same-cycle clear of index, phase, done, err and checksum; a same-cycle nibble is ignored.
  - A write already scheduled in the output register still completes.
  - start during a partial record discards that record without setting err.
- checksum: 8-bit wrap-around add of the zero-extended nibble on every accept.
- busy is combinational from phase: (phase==HI || phase==TH).
- Reset mid-record: all state is cleared and any pending wr_en is suppressed in the next cycle.

Test Plan:
- Single record: reset, then nibbles 0x0,0xF,0x5 on 3 consecutive accept cycles → wr_en pulse 1 cycle after the 3rd accept with wr_addr=0, wr_weight=0xF0, wr_thresh=0x5; checksum=0x14; busy high for 2 cycles.
- Full load:
  - Stimulus: 60 nibbles, where neuron n = {lo=n[3:0], hi=0xA, th=0x3}.
  - Required: 20 wr_en pulses with addr 0..19, last weight=0xA3; done=1 after the 60th accept.
  - Required: a 61st nibble produces no wr_en and leaves checksum unchanged.
- Truncation: for neuron 4, send lo=0x1, hi=0x2, then drop load_en with ena=1 → err=1, busy=0, no wr_en; resend 0x7,0x8,0x9 → write addr=4, weight=0x87, thresh=0x9.
- ena gating: in phase HI, hold ena=0 with load_en=0 for 5 cycles → no err, phase held; resume with the TH nibble → write occurs.
- start mid-record: after 2 nibbles of neuron 0, pulse start → busy=0, err=0, checksum=0; the next 3 nibbles write addr 0.
- Reset mid-record: assert reset in the cycle the TH nibble arrives → no wr_en in the following cycle and all outputs are 0.

Source files
------------

// File: rtl/bnn_param_loader.sv
// bnn_param_loader
// Collects a 4-bit nibble stream into per-neuron parameter records for the
// 8-8-4 BNN core. Each record is three nibbles: weight[3:0], weight[7:4] and
// threshold[3:0]. One registered write strobe is issued per completed record.
// The block also tracks load progress, flags truncated records and keeps a
// running checksum of every accepted nibble.
module bnn_param_loader #(
  parameter int NUM_NEURONS = 20,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              start,
  input  logic              load_en,
  input  logic [3:0]        nibble,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_weight,
  output logic [3:0]        wr_thresh,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  // Position of the next expected nibble inside the current record.
  typedef enum logic [1:0] {
    PH_LO = 2'd0,
    PH_HI = 2'd1,
    PH_TH = 2'd2
  } phase_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  phase_t            phase_reg;
  logic [ADDR_W-1:0] index_reg;
  logic [3:0]        lo_reg;
  logic [3:0]        hi_reg;
  logic              accept;
  logic              truncate;

  // A nibble is taken only when enabled, qualified, not finished and not
  // being overridden by a restart in the same cycle.
  assign accept   = ena && load_en && !done && !start;

  // A gap in load_en while a record is partially received means the host
  // aborted mid-record. With ena low the stream is simply paused.
  assign truncate = ena && !load_en && (phase_reg != PH_LO);

  // Partial-record indicator comes straight from the phase.
  assign busy = (phase_reg == PH_HI) || (phase_reg == PH_TH);

  // Record assembly, write strobe generation, progress and status tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= PH_LO;
      index_reg <= '0;
      lo_reg    <= 4'h0;
      hi_reg    <= 4'h0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_weight <= 8'h00;
      wr_thresh <= 4'h0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= 8'h00;
    end else begin
      // The strobe is a single-cycle pulse; address and data hold.
      wr_en <= 1'b0;
      if (start) begin
        // Restart discards any partial record silently; a write already in
        // the output register has been presented and is not disturbed.
        phase_reg <= PH_LO;
        index_reg <= '0;
        done      <= 1'b0;
        err       <= 1'b0;
        checksum  <= 8'h00;
      end else if (accept) begin
        checksum <= checksum + {4'h0, nibble};
        case (phase_reg)
          PH_LO: begin
            lo_reg    <= nibble;
            phase_reg <= PH_HI;
          end
          PH_HI: begin
            hi_reg    <= nibble;
            phase_reg <= PH_TH;
          end
          PH_TH: begin
            phase_reg <= PH_LO;
            wr_en     <= 1'b1;
            wr_addr   <= index_reg;
            wr_weight <= {hi_reg, lo_reg};
            wr_thresh <= nibble;
            // The index saturates on the last neuron so wr_addr never
            // points past the parameter store.
            if (index_reg == LAST_IDX) begin
              done <= 1'b1;
            end else begin
              index_reg <= index_reg + 1'b1;
            end
          end
          default: begin
            phase_reg <= PH_LO;
          end
        endcase
      end else if (truncate) begin
        // Drop the partial record; the same neuron index is reloaded next.
        err       <= 1'b1;
        phase_reg <= PH_LO;
      end
    end
  end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Testbench for bnn_param_loader: a table of hand-computed vectors, directed
// sequences for the multi-cycle corner cases, and a long randomized run
// checked against a queue-based behavioural model.
module tb_bnn_param_loader;

  localparam int NUM_NEURONS = 20;
  localparam int ADDR_W      = 5;

  logic              clk;
  logic              reset;
  logic              ena;
  logic              start;
  logic              load_en;
  logic [3:0]        nibble;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_weight;
  logic [3:0]        wr_thresh;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        checksum;

  int total = 0;
  int bad   = 0;

  bnn_param_loader #(
    .NUM_NEURONS(NUM_NEURONS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .start    (start),
    .load_en  (load_en),
    .nibble   (nibble),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_weight(wr_weight),
    .wr_thresh(wr_thresh),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a record is just a list of the nibbles received so far.
  logic [3:0] m_part[$];
  int         m_idx;
  logic       m_done;
  logic       m_err;
  logic [7:0] m_cs;
  logic       m_wr;
  int         m_addr;
  logic [7:0] m_w;
  logic [3:0] m_t;

  task automatic model_step(input logic r, input logic s, input logic e,
                            input logic l, input logic [3:0] n);
    if (r) begin
      m_part.delete();
      m_idx = 0; m_done = 1'b0; m_err = 1'b0; m_cs = 8'h00;
      m_wr = 1'b0; m_addr = 0; m_w = 8'h00; m_t = 4'h0;
    end else begin
      m_wr = 1'b0;
      if (s) begin
        m_part.delete();
        m_idx = 0; m_done = 1'b0; m_err = 1'b0; m_cs = 8'h00;
      end else if (e && l && !m_done) begin
        m_cs = 8'((int'(m_cs) + int'(n)) % 256);
        m_part.push_back(n);
        if (m_part.size() == 3) begin
          m_wr   = 1'b1;
          m_addr = m_idx;
          m_w    = {m_part[1], m_part[0]};
          m_t    = m_part[2];
          m_part.delete();
          if (m_idx == NUM_NEURONS - 1) m_done = 1'b1;
          else m_idx = m_idx + 1;
        end
      end else if (e && !l && m_part.size() != 0) begin
        m_err = 1'b1;
        m_part.delete();
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, clock it, advance the model, settle.
  task automatic drive(input logic r, input logic s, input logic e,
                       input logic l, input logic [3:0] n);
    reset = r; start = s; ena = e; load_en = l; nibble = n;
    @(posedge clk);
    model_step(r, s, e, l, n);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wr_en"},     int'(wr_en),     int'(m_wr));
    chk({tag, ".wr_addr"},   int'(wr_addr),   m_addr);
    chk({tag, ".wr_weight"}, int'(wr_weight), int'(m_w));
    chk({tag, ".wr_thresh"}, int'(wr_thresh), int'(m_t));
    chk({tag, ".busy"},      int'(busy),      int'(m_part.size() != 0));
    chk({tag, ".done"},      int'(done),      int'(m_done));
    chk({tag, ".err"},       int'(err),       int'(m_err));
    chk({tag, ".checksum"},  int'(checksum),  int'(m_cs));
  endtask

  typedef struct {
    logic       r, s, e, l;
    logic [3:0] n;
    logic       x_wr;
    logic [4:0] x_addr;
    logic [7:0] x_w;
    logic [3:0] x_t;
    logic       x_busy, x_done, x_err;
    logic [7:0] x_cs;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int writes;
    logic [3:0] a, b, c;
    reset = 1'b1; start = 1'b0; ena = 1'b0; load_en = 1'b0; nibble = 4'h0;

    // Single record 0,F,5 then reset arriving with a TH nibble.
    tbl[0] = '{1'b1,1'b0,1'b0,1'b0,4'h0, 1'b0,5'd0,8'h00,4'h0, 1'b0,1'b0,1'b0,8'h00};
    tbl[1] = '{1'b0,1'b0,1'b1,1'b1,4'h0, 1'b0,5'd0,8'h00,4'h0, 1'b1,1'b0,1'b0,8'h00};
    tbl[2] = '{1'b0,1'b0,1'b1,1'b1,4'hF, 1'b0,5'd0,8'h00,4'h0, 1'b1,1'b0,1'b0,8'h0F};
    tbl[3] = '{1'b0,1'b0,1'b1,1'b1,4'h5, 1'b1,5'd0,8'hF0,4'h5, 1'b0,1'b0,1'b0,8'h14};
    tbl[4] = '{1'b0,1'b0,1'b1,1'b0,4'h0, 1'b0,5'd0,8'hF0,4'h5, 1'b0,1'b0,1'b0,8'h14};
    tbl[5] = '{1'b0,1'b0,1'b1,1'b1,4'h1, 1'b0,5'd0,8'hF0,4'h5, 1'b1,1'b0,1'b0,8'h15};
    tbl[6] = '{1'b0,1'b0,1'b1,1'b1,4'h2, 1'b0,5'd0,8'hF0,4'h5, 1'b1,1'b0,1'b0,8'h17};
    tbl[7] = '{1'b1,1'b0,1'b1,1'b1,4'h3, 1'b0,5'd0,8'h00,4'h0, 1'b0,1'b0,1'b0,8'h00};
    tbl[8] = '{1'b0,1'b0,1'b1,1'b0,4'h0, 1'b0,5'd0,8'h00,4'h0, 1'b0,1'b0,1'b0,8'h00};

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].l, tbl[i].n);
      chk($sformatf("tbl%0d.wr_en", i),     int'(wr_en),     int'(tbl[i].x_wr));
      chk($sformatf("tbl%0d.wr_addr", i),   int'(wr_addr),   int'(tbl[i].x_addr));
      chk($sformatf("tbl%0d.wr_weight", i), int'(wr_weight), int'(tbl[i].x_w));
      chk($sformatf("tbl%0d.wr_thresh", i), int'(wr_thresh), int'(tbl[i].x_t));
      chk($sformatf("tbl%0d.busy", i),      int'(busy),      int'(tbl[i].x_busy));
      chk($sformatf("tbl%0d.done", i),      int'(done),      int'(tbl[i].x_done));
      chk($sformatf("tbl%0d.err", i),       int'(err),       int'(tbl[i].x_err));
      chk($sformatf("tbl%0d.checksum", i),  int'(checksum),  int'(tbl[i].x_cs));
      $display("vec %0d: wr_en=%0d addr=%0d w=%02h t=%0h busy=%0d done=%0d err=%0d cs=%02h",
               i, wr_en, wr_addr, wr_weight, wr_thresh, busy, done, err, checksum);
    end

    // Full load: neuron n = {lo=n[3:0], hi=A, th=3}.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    writes = 0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, 1'b0, 1'b1, 1'b1, (k == 0) ? 4'(n) : ((k == 1) ? 4'hA : 4'h3));
        check_model("full");
        if (wr_en) begin
          chk("full.addr_order", int'(wr_addr), writes);
          $display("full load write: addr=%0d w=%02h t=%0h", wr_addr, wr_weight, wr_thresh);
          writes++;
        end
      end
    end
    chk("full.write_count", writes, 20);
    chk("full.last_weight", int'(wr_weight), 'hA3);
    chk("full.done", int'(done), 1);
    chk("full.checksum", int'(checksum), 'h82);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    check_model("full61");
    chk("full61.wr_en", int'(wr_en), 0);
    chk("full61.checksum", int'(checksum), 'h82);
    chk("full61.done", int'(done), 1);
    $display("full load: writes=%0d done=%0d cs=%02h", writes, done, checksum);

    // Truncation on neuron 4, then reload of the same neuron.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'($urandom_range(15)));
      check_model("trunc.pre");
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check_model("trunc");
    chk("trunc.err", int'(err), 1);
    chk("trunc.busy", int'(busy), 0);
    chk("trunc.wr_en", int'(wr_en), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h8);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h9);
    check_model("reload");
    chk("reload.wr_en", int'(wr_en), 1);
    chk("reload.addr", int'(wr_addr), 4);
    chk("reload.weight", int'(wr_weight), 'h87);
    chk("reload.thresh", int'(wr_thresh), 'h9);
    $display("truncation: err=%0d reload addr=%0d w=%02h t=%0h", err, wr_addr, wr_weight, wr_thresh);

    // start mid-record clears err, index and checksum without raising err.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h5);
    check_model("start");
    chk("start.busy", int'(busy), 0);
    chk("start.err", int'(err), 0);
    chk("start.checksum", int'(checksum), 0);
    a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); c = 4'($urandom_range(15));
    drive(1'b0, 1'b0, 1'b1, 1'b1, a);
    drive(1'b0, 1'b0, 1'b1, 1'b1, b);
    drive(1'b0, 1'b0, 1'b1, 1'b1, c);
    check_model("start.rec");
    chk("start.rec.wr_en", int'(wr_en), 1);
    chk("start.rec.addr", int'(wr_addr), 0);
    chk("start.rec.weight", int'(wr_weight), int'({b, a}));
    chk("start.rec.checksum", int'(checksum), int'(a) + int'(b) + int'(c));
    $display("start mid-record: addr=%0d w=%02h cs=%02h", wr_addr, wr_weight, checksum);

    // ena low pauses the stream mid-record with no truncation.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hC);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk("gate.err", int'(err), 0);
      chk("gate.busy", int'(busy), 1);
      chk("gate.wr_en", int'(wr_en), 0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hD);
    check_model("gate.resume");
    chk("gate.resume.wr_en", int'(wr_en), 1);
    chk("gate.resume.weight", int'(wr_weight), 'hC6);
    chk("gate.resume.thresh", int'(wr_thresh), 'hD);
    $display("ena gating: wr_en=%0d w=%02h t=%0h err=%0d", wr_en, wr_weight, wr_thresh, err);

    // Randomized run against the model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(199) == 0), 1'($urandom_range(39) == 0),
            1'($urandom_range(9) != 0), 1'($urandom_range(19) < 17),
            4'($urandom_range(15)));
      check_model("rand");
    end
    $display("random run: 3000 cycles, final cs=%02h done=%0d err=%0d", checksum, done, err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
